// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-side handshake between a byte source (FIFO/bus) and the UART transmitter.
//   uart_data     byte to transmit
//   uart_data_wr  one-cycle write strobe
//   uart_tx_rdy   holding register empty; a write in this cycle is accepted
//   uart_tx_busy  frame in progress or holding register full
//   uart_tx_ovf   one-cycle pulse after a write that arrived while not ready
// master = byte source, slave = transmitter.
interface uart_tx_if;
  logic [7:0] uart_data;
  logic       uart_data_wr;
  logic       uart_tx_rdy;
  logic       uart_tx_busy;
  logic       uart_tx_ovf;

  modport master (
    output uart_data,
    output uart_data_wr,
    input  uart_tx_rdy,
    input  uart_tx_busy,
    input  uart_tx_ovf
  );

  modport slave (
    input  uart_data,
    input  uart_data_wr,
    output uart_tx_rdy,
    output uart_tx_busy,
    output uart_tx_ovf
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1, LSB-first UART transmitter for the MIDI OUT ports.
// Bit timing counts pulses of an oversampled clock enable, so every line level
// lasts exactly OVERSAMPLE clk_en pulses regardless of how they are spaced.
// A one-byte holding register sits in front of the shift register so the next
// byte can be queued while the current one shifts; a queued byte follows the
// stop bit directly, with no idle bit in between.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high; line returns high at once
//   clk_en    one-cycle oversample enable (OVERSAMPLE pulses per bit)
//   bus       uart_tx_if.slave byte handshake (data, wr, rdy, busy, ovf)
//   uart_out  serial line, registered, idle high
module uart_tx #(
  parameter int OVERSAMPLE = 8  // clk_en pulses per bit, 2..16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  uart_tx_if.slave   bus,
  output logic       uart_out
);

  localparam int            SW     = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [SW-1:0] s, s_n;
  logic [2:0]    b, b_n;
  logic [7:0]    hold;
  logic [7:0]    shift, shift_n;
  logic          hold_full;
  logic          ovf;
  logic          accept;
  logic          load;
  logic          bit_end;
  logic          out_n;

  // A write is only taken into an empty holding register; a transfer to the
  // shifter only happens from a full one, so the two never coincide.
  assign accept           = bus.uart_data_wr & ~hold_full;
  assign bus.uart_tx_rdy  = ~hold_full;
  assign bus.uart_tx_busy = (state != IDLE) | hold_full;
  assign bus.uart_tx_ovf  = ovf;

  assign bit_end = clk_en & (s == S_LAST);

  always_comb begin
    state_n = state;
    s_n     = s;
    b_n     = b;
    load    = 1'b0;
    shift_n = shift;
    out_n   = 1'b1;

    if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            load    = 1'b1;
            s_n     = '0;
            state_n = START;
          end
        end
        START: begin
          if (bit_end) begin
            s_n     = '0;
            b_n     = 3'd0;
            state_n = DATA;
          end else begin
            s_n = s + SW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            s_n = '0;
            if (b == 3'd7) state_n = STOP;
            else           b_n     = b + 3'd1;
          end else begin
            s_n = s + SW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            s_n = '0;
            // Queued byte: its start bit begins on this same pulse.
            if (hold_full) begin
              load    = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (load) shift_n = hold;

    // The line register takes the level of the state being entered, so each
    // level changes exactly on the pulse that starts its bit.
    unique case (state_n)
      START:   out_n = 1'b0;
      DATA:    out_n = shift_n[b_n];
      default: out_n = 1'b1;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s         <= '0;
      b         <= 3'd0;
      hold_full <= 1'b0;
      ovf       <= 1'b0;
      uart_out  <= 1'b1;
    end else begin
      state    <= state_n;
      s        <= s_n;
      b        <= b_n;
      ovf      <= bus.uart_data_wr & hold_full;
      uart_out <= out_n;
      if (accept)    hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;
    end
  end

  // Data registers; their contents are only used while the matching control
  // flags say they are valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) hold <= bus.uart_data;
    shift <= shift_n;
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
  localparam int OS = 8;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  logic uart_out;

  uart_tx_if bus ();

  uart_tx #(.OVERSAMPLE(OS)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .bus      (bus),
    .uart_out (uart_out)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         epoch = 0;
  int         en_mode = 0;   // 0: every 8 clk, 1: alternate 5/11, 2: random 1..4
  int         ovf_seen = 0;
  int         ovf_exp = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // clk_en generator
  initial begin
    bit alt;
    int g;
    alt    = 1'b0;
    clk_en = 1'b0;
    forever begin
      case (en_mode)
        0:       g = 8;
        1:       begin g = alt ? 11 : 5; alt = ~alt; end
        default: g = $urandom_range(1, 4);
      endcase
      repeat (g - 1) begin @(posedge clk); #1 clk_en = 1'b0; end
      @(posedge clk); #1 clk_en = 1'b1;
    end
  end

  // overflow pulse counter
  initial begin
    forever begin
      @(negedge clk);
      if (bus.uart_tx_ovf === 1'b1) ovf_seen++;
    end
  end

  // Line level during the clk_en period that ends at the next rising edge.
  task automatic get_pulse(output logic v);
    do @(negedge clk); while (clk_en !== 1'b1);
    v = uart_out;
  endtask

  // Monitor: decodes frames in units of clk_en pulses and checks them against the scoreboard.
  initial begin
    logic        v;
    logic [79:0] smp;
    int          ep;
    int          stable;
    logic [7:0]  byte_v;
    logic [7:0]  e;
    forever begin
      get_pulse(v);
      if (reset !== 1'b0 || v !== 1'b0) continue;
      ep     = epoch;
      smp    = '0;
      smp[0] = v;
      for (int i = 1; i < 80; i++) begin
        get_pulse(v);
        smp[i] = v;
      end
      if (ep != epoch) continue;  // frame cut by reset
      stable = 1;
      for (int k = 0; k < 10; k++)
        for (int j = 1; j < 8; j++)
          if (smp[k*8+j] !== smp[k*8]) stable = 0;
      chk("bit_stable_8_pulses", stable, 1);
      chk("stop_bit", int'(smp[72]), 1);
      for (int k = 0; k < 8; k++) byte_v[k] = smp[8 + 8*k];
      chk("frame_was_queued", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rx_byte", int'(byte_v), int'(e));
      end
    end
  end

  // Write d; with dup the strobe stays high one more cycle carrying drop,
  // which must be rejected because the holding register was just filled.
  task automatic send(input logic [7:0] d, input bit dup, input logic [7:0] drop);
    bus.uart_data    = d;
    bus.uart_data_wr = 1'b1;
    exp_q.push_back(d);
    @(posedge clk); #1;
    if (dup) begin
      chk("rdy_while_full", int'(bus.uart_tx_rdy), 0);
      bus.uart_data = drop;
      ovf_exp++;
      @(posedge clk); #1;
    end
    bus.uart_data_wr = 1'b0;
    if (dup) begin
      chk("ovf_pulse", int'(bus.uart_tx_ovf), 1);
      @(posedge clk); #1;
      chk("ovf_single_cycle", int'(bus.uart_tx_ovf), 0);
    end
  endtask

  task automatic wait_rdy();
    int t = 0;
    while (bus.uart_tx_rdy !== 1'b1 && t < 3000) begin @(posedge clk); #1; t++; end
    chk("rdy_wait", int'(bus.uart_tx_rdy === 1'b1), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.uart_tx_busy !== 1'b0 && t < 20000) begin @(posedge clk); #1; t++; end
    chk("idle_wait", int'(bus.uart_tx_busy === 1'b0), 1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  // clk cycles from the start bit's falling edge until busy drops
  task automatic measure_frame(output int n);
    int t = 0;
    n = -1;
    while (uart_out !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    if (uart_out === 1'b0) begin
      n = 0;
      while (bus.uart_tx_busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    end
  endtask

  task automatic idle_window(input string name);
    int errs = 0;
    repeat (1000) begin
      @(negedge clk);
      if (uart_out !== 1'b1 || bus.uart_tx_rdy !== 1'b1 ||
          bus.uart_tx_busy !== 1'b0 || bus.uart_tx_ovf !== 1'b0) errs++;
    end
    chk(name, errs, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int n;
    int t;
    logic [7:0] d;
    reset            = 1'b0;
    bus.uart_data    = 8'h00;
    bus.uart_data_wr = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("reset_line", int'(uart_out), 1);
    chk("reset_rdy", int'(bus.uart_tx_rdy), 1);
    chk("reset_busy", int'(bus.uart_tx_busy), 0);
    chk("reset_ovf", int'(bus.uart_tx_ovf), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_window("idle_after_reset");

    // single byte, 64 clk per bit
    @(posedge clk); #1;
    send(8'hDE, 1'b0, 8'h00);
    chk("rdy_after_write", int'(bus.uart_tx_rdy), 0);
    chk("busy_after_write", int'(bus.uart_tx_busy), 1);
    measure_frame(n);
    chk("single_frame_clk", n, 640);
    wait_idle();

    // back-to-back note-on
    fork
      measure_frame(n);
      begin
        send(8'h90, 1'b0, 8'h00);
        wait_rdy();
        send(8'h3C, 1'b0, 8'h00);
        wait_rdy();
        send(8'h7F, 1'b0, 8'h00);
      end
    join
    chk("back_to_back_clk", n, 1920);
    wait_idle();

    // overflow: 0x33 arrives while the holding register holds 0xAA
    send(8'h55, 1'b0, 8'h00);
    wait_rdy();
    send(8'hAA, 1'b1, 8'h33);
    wait_idle();

    // reset in the middle of data bit 3 of 0xA5 (bit 3 is 0)
    send(8'hA5, 1'b0, 8'h00);
    t = 0;
    while (uart_out !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    repeat (280) @(negedge clk);
    chk("bit3_level", int'(uart_out), 0);
    #2 reset = 1'b1;
    epoch++;
    exp_q.delete();
    #1;
    chk("async_reset_line", int'(uart_out), 1);
    chk("async_reset_rdy", int'(bus.uart_tx_rdy), 1);
    chk("async_reset_busy", int'(bus.uart_tx_busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_window("idle_after_midframe_reset");

    // irregular clk_en spacing
    en_mode = 1;
    repeat (30) @(posedge clk);
    #1;
    send(8'h01, 1'b0, 8'h00);
    wait_idle();

    // randomized traffic with random clk_en spacing and occasional overflows
    en_mode = 2;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      wait_rdy();
      send(d, ($urandom_range(0, 3) == 0), 8'($urandom));
      repeat ($urandom_range(0, 150)) @(posedge clk);
      #1;
    end
    wait_idle();

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("ovf_total", ovf_seen, ovf_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
